// File: rtl/keypad_pkg.sv
// keypad_pkg: shared scan-state type and key-map helpers for the keypad scanner
package keypad_pkg;
  typedef enum logic [0:0] {SCAN = 1'b0, EVAL = 1'b1} scan_state_t;
  localparam int MAX_KEYS = 64;
  function automatic int key_index(input int row, input int col, input int n_cols);
    return row * n_cols + col;
  endfunction
  function automatic int popcount(input logic [MAX_KEYS-1:0] map);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n += map[i] ? 1 : 0;
    return n;
  endfunction
endpackage

// File: rtl/keypad_encode.sv
// keypad_encode: single-key flag, key code and key count of a debounced key map
module keypad_encode
  import keypad_pkg::*;
#(
  parameter int N_KEYS = 16,
  parameter int KW = 4,
  parameter int CW = 5
) (
  input  logic [N_KEYS-1:0] map_i,
  output logic              onehot_o,
  output logic [KW-1:0]     code_o,
  output logic [CW-1:0]     count_o
);
  // lowest pressed index; only meaningful when exactly one key is down
  always_comb begin
    code_o = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) if (map_i[i]) code_o = KW'(i);
  end
  assign count_o = CW'(popcount(MAX_KEYS'(map_i)));
  assign onehot_o = count_o == CW'(1);
endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: column-scanning keypad front end with full-map debounce and key events
// Optional auto-repeat of a held single key: define KEYPAD_REPEAT_EN.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int SCAN_TICKS = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS = 50,
  localparam int NK = N_ROWS * N_COLS,
  localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CW = $clog2(NK + 1);
  localparam int CLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N_COLS - 1);
  localparam logic [SW-1:0] CNT_FULL = SW'(DEBOUNCE_SCANS);

  if (SCAN_TICKS < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
    $error("keypad_scan_debounce: invalid timing parameters");
  end

  logic [N_ROWS-1:0] sync1_q, sync2_q;
  scan_state_t       state_q, state_d;
  logic [CLW-1:0]    col_q, col_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [NK-1:0]     raw_q, raw_d, prev_q, prev_d, stable_q, stable_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [N_COLS-1:0] col_out_q, col_out_d;
  logic              upd_q, upd_d;
  logic [KW-1:0]     key_code_q;
  logic              key_valid_q, key_held_q, multi_q;
  logic              enc_onehot, evt, rep_fire_q;
  logic [KW-1:0]     enc_code;
  logic [CW-1:0]     enc_count;

  keypad_encode #(.N_KEYS(NK), .KW(KW), .CW(CW)) u_enc (
    .map_i(stable_q),
    .onehot_o(enc_onehot),
    .code_o(enc_code),
    .count_o(enc_count)
  );

  // column sequencing, raw capture at the end of each column and full-map debounce
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    tick_d = tick_q;
    raw_d = raw_q;
    prev_d = prev_q;
    cnt_d = cnt_q;
    stable_d = stable_q;
    if (state_q == SCAN) begin
      tick_d = tick_q + TW'(1);
      if (tick_q == TICK_LAST) begin
        for (int r = 0; r < N_ROWS; r++) raw_d[key_index(r, int'(col_q), N_COLS)] = ~sync2_q[r];
        tick_d = '0;
        state_d = (col_q == COL_LAST) ? EVAL : SCAN;
        col_d = (col_q == COL_LAST) ? col_q : col_q + CLW'(1);
      end
    end else begin
      prev_d = raw_q;
      cnt_d = (raw_q != prev_q) ? SW'(1) : (cnt_q == CNT_FULL) ? cnt_q : cnt_q + SW'(1);
      stable_d = (cnt_d == CNT_FULL) ? prev_d : stable_q;
      state_d = SCAN;
      col_d = '0;
    end
    col_out_d = (state_d == SCAN) ? ~(N_COLS'(1) << col_d) : '1;
    upd_d = (state_q == EVAL) && (stable_d != stable_q);
  end

  // synchronizer, scan state and debounce registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= SCAN;
      col_q <= '0;
      tick_q <= '0;
      raw_q <= '0;
      prev_q <= '0;
      stable_q <= '0;
      cnt_q <= '0;
      col_out_q <= '1;
      upd_q <= 1'b0;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      col_q <= col_d;
      tick_q <= tick_d;
      raw_q <= raw_d;
      prev_q <= prev_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      col_out_q <= col_out_d;
      upd_q <= upd_d;
    end
  end

  // a fresh single key counts only if the previous map was empty or single; multi_q still holds the old map
  assign evt = upd_q && enc_onehot && !multi_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q;
  logic          armed_q;
  // auto-repeat counts evaluations while an accepted single key stays stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
      rep_fire_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      rep_fire_q <= 1'b0;
      if (upd_d) begin
        rep_q <= '0;
        armed_q <= 1'b0;
      end else if (evt) begin
        armed_q <= 1'b1;
      end else if (state_q == EVAL && armed_q) begin
        rep_fire_q <= rep_q == RW'(REPEAT_SCANS - 1);
        rep_q <= (rep_q == RW'(REPEAT_SCANS - 1)) ? '0 : rep_q + RW'(1);
      end
    end
  end
`else
  assign rep_fire_q = 1'b0;
`endif

  // event and flag registers follow the stable map one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      key_held_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      key_code_q <= evt ? enc_code : key_code_q;
      key_valid_q <= evt || rep_fire_q;
      key_held_q <= enc_count != '0;
      multi_q <= enc_count > CW'(1);
    end
  end

  assign col_out = col_out_q;
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held = key_held_q;
  assign multi_key = multi_q;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: keypad matrix emulation, scan-timing reference model and randomized presses
module tb_keypad_scan_debounce;
  localparam int NR = 4, NC = 4, ST = 4, DB = 3, RP = 5, NK = NR * NC, P = NC * ST + 1;

  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] row_in;
  logic [NC-1:0] col_out;
  logic [3:0] key_code;
  logic key_valid, key_held, multi_key;
  logic [NK-1:0] keys = '0;
  int n_cmp = 0, n_bad = 0, pulses = 0, edge_n = 0;

  keypad_scan_debounce #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RP)
  ) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // passive matrix: a row reads low when a pressed key sits on a driven column
  always_comb begin
    row_in = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (!col_out[c] && keys[r*NC+c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;
  always @(negedge clk) if (key_valid) pulses++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // reference model: scans are pure arithmetic on the edge count since reset release
  logic [NK-1:0] hist [8];
  logic [NK-1:0] raw_m, stable_m, old_m;
  logic [NK-1:0] scans[$];
  logic [3:0] code_m, pend_code;
  bit evt_pend, armed_m, same;
  int rep_m;
  always @(negedge clk) begin
    int n, pp, c;
    logic exp_valid, exp_held, exp_multi;
    logic [NC-1:0] exp_col;
    n = edge_n;
    hist[n & 7] = keys;
    if (rst || n == 0) begin
      raw_m = '0; stable_m = '0; scans.delete();
      evt_pend = 0; armed_m = 0; rep_m = 0; code_m = '0;
      check("rst_col_out", col_out, 4'hF);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_held", key_held, 0);
      check("rst_multi_key", multi_key, 0);
      check("rst_key_code", key_code, 0);
    end else begin
      exp_valid = evt_pend;
      if (evt_pend) code_m = pend_code;
      evt_pend = 0;
      exp_held = stable_m != '0;
      exp_multi = $countones(stable_m) >= 2;
      pp = (n + P - 1) % P;
      if (pp < NC * ST && pp % ST == ST - 1) begin
        c = pp / ST;
        for (int r = 0; r < NR; r++) raw_m[r*NC+c] = hist[(n-3) & 7][r*NC+c];
      end
      if (pp == NC * ST) begin
        scans.push_back(raw_m);
        if (scans.size() > DB) void'(scans.pop_front());
        same = scans.size() == DB;
        foreach (scans[i]) if (scans[i] != raw_m) same = 0;
        if (same && raw_m != stable_m) begin
          old_m = stable_m;
          stable_m = raw_m;
          rep_m = 0;
          armed_m = $countones(raw_m) == 1 && (old_m == '0 || $countones(old_m) == 1);
          if (armed_m) begin
            evt_pend = 1;
            for (int k = NK - 1; k >= 0; k--) if (raw_m[k]) pend_code = 4'(k);
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (armed_m) begin
          rep_m++;
          if (rep_m == RP) begin
            rep_m = 0;
            evt_pend = 1;
            pend_code = code_m;
          end
        end
`endif
      end
      exp_col = (n % P < NC * ST) ? ~(4'b0001 << ((n % P) / ST)) : 4'hF;
      check("col_out", col_out, exp_col);
      check("key_valid", key_valid, exp_valid);
      check("key_held", key_held, exp_held);
      check("multi_key", multi_key, exp_multi);
      check("key_code", key_code, code_m);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base, sel;
    logic [NK-1:0] m;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    // idle scan pattern pinned to literal column drives
    cyc(1);
    check("t1_col_e1", col_out, 4'b1110);
    cyc(4);
    check("t1_col_e5", col_out, 4'b1101);
    cyc(11);
    check("t1_col_e16", col_out, 4'b1111);
    cyc(1);
    check("t1_col_e17", col_out, 4'b1110);
    base = pulses;
    cyc(3 * P);
    check("t1_pulses", pulses - base, 0);
    check("t1_held", key_held, 0);
    // single key row 2 col 1, then release
    keys = 16'h0200;
    base = pulses;
    cyc(5 * P);
    check("t2_pulses", pulses - base, 1);
    check("t2_code", key_code, 9);
    check("t2_held", key_held, 1);
    keys = '0;
    base = pulses;
    cyc(5 * P);
    check("t2_rel_pulses", pulses - base, 0);
    check("t2_rel_held", key_held, 0);
    // bounce on key 3, then steady
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      keys[3] = ~keys[3];
      cyc(20);
    end
    check("t3_bounce_pulses", pulses - base, 0);
    keys = 16'h0008;
    base = pulses;
    cyc(5 * P);
    check("t3_pulses", pulses - base, 1);
    check("t3_code", key_code, 3);
    keys = '0;
    cyc(5 * P);
    // multi-key, partial release, full release, new press
    keys = 16'h0021;
    base = pulses;
    cyc(5 * P);
    check("t4_multi", multi_key, 1);
    check("t4_held", key_held, 1);
    keys = 16'h0001;
    cyc(5 * P);
    check("t4_multi_off", multi_key, 0);
    check("t4_no_ghost", pulses - base, 0);
    keys = '0;
    cyc(5 * P);
    keys = 16'h0020;
    cyc(5 * P);
    check("t4_pulses", pulses - base, 1);
    check("t4_code", key_code, 5);
    keys = '0;
    cyc(5 * P);
    // reset mid-scan while key 15 is held
    keys = 16'h8000;
    cyc(5 * P);
    check("t5_code_pre", key_code, 15);
    cyc(6);
    rst = 1'b1;
    #1;
    check("t5_rst_col", col_out, 4'hF);
    check("t5_rst_code", key_code, 0);
    check("t5_rst_held", key_held, 0);
    cyc(3);
    rst = 1'b0;
    base = pulses;
    cyc(5 * P);
    check("t5_pulses", pulses - base, 1);
    check("t5_code", key_code, 15);
    keys = '0;
    cyc(5 * P);
    // long hold of key 7
    keys = 16'h0080;
    base = pulses;
    cyc(12 * P);
`ifdef KEYPAD_REPEAT_EN
    check("t6_pulses", pulses - base, 2);
`else
    check("t6_pulses", pulses - base, 1);
`endif
    check("t6_code", key_code, 7);
    keys = '0;
    cyc(5 * P);
    // randomized presses at arbitrary phase
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      m = '0;
      if (sel >= 3) m[$urandom_range(0, NK-1)] = 1'b1;
      if (sel >= 8) m[$urandom_range(0, NK-1)] = 1'b1;
      keys = m;
      cyc($urandom_range(5, 90));
    end
    keys = '0;
    cyc(5 * P);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
